wb_timer: RTL
=============

WB_TIMER -- requirements
Module: wb_timer

Interface
REQ-001 SHALL have parameter RESET_LOAD, default 32'h0000_0000, reset value of LOAD register.
REQ-002 SHALL have parameter IRQ_LEVEL, default 1, 1 = level irq_o, 0 = one-cycle pulse on expiry.
REQ-003 SHALL have port wb_clk_i input 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port wb_rst_ni input 1, asynchronous active-low reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port wbs_adr_i input 32, byte address; only bits [4:2] decoded.
REQ-006 SHALL have port wbs_dat_i input 32, write data.
REQ-007 SHALL have port wbs_dat_o output 32, read data.
REQ-008 SHALL have port wbs_we_i input 1, write enable.
REQ-009 SHALL have port wbs_sel_i input 4, byte lanes; bit n enables bits [8n+7:8n].
REQ-010 SHALL have port wbs_stb_i input 1, strobe.
REQ-011 SHALL have port wbs_cyc_i input 1, cycle.
REQ-012 SHALL have port wbs_ack_o output 1, acknowledge.
REQ-013 SHALL have port irq_o output 1, interrupt to CPU irq line.

Function
REQ-014 SHALL implement a Wishbone classic slave: request = cyc & stb & !ack; ack asserted exactly one cycle after request, held one cycle, then low for at least one cycle.
REQ-015 SHALL perform write side effects in the request cycle that produces ack; read data valid while ack high, zero otherwise.
REQ-016 SHALL decode offsets: 0x00 CTRL (bit0 EN, bit1 AUTO, bit2 IRQ_EN, others read 0), 0x04 LOAD, 0x08 COUNT, 0x0C STATUS (bit0 EXP), 0x10 PRESCALE (see Configuration); 0x14-0x1C read 0, writes ignored.
REQ-017 SHALL apply wbs_sel_i per byte on CTRL, LOAD, COUNT, PRESCALE writes.
REQ-018 SHALL decrement COUNT by 1 on each tick while EN=1 and COUNT!=0; tick = every cycle unless prescaler enabled.
REQ-019 SHALL, on a tick with COUNT==1, set EXP, then COUNT<=LOAD if AUTO=1 else COUNT<=0 and EN<=0.
REQ-020 SHALL, with EN=1 and COUNT==0 (e.g. LOAD=0), hold COUNT at 0, set no EXP.
REQ-021 SHALL clear EXP on STATUS write with wbs_dat_i[0]=1 and sel[0]=1; expiry in same cycle wins (EXP stays 1).
REQ-022 SHALL let a bus write to COUNT or CTRL override the counter update of the same cycle.
REQ-023 SHALL drive irq_o = EXP & IRQ_EN when IRQ_LEVEL=1; else registered one-cycle pulse on the EXP set event when IRQ_EN=1.
REQ-024 SHALL ignore strobes with cyc low.

Reset
REQ-025 SHALL on wb_rst_ni low immediately clear wbs_ack_o, irq_o, wbs_dat_o, CTRL, COUNT, EXP, PRESCALE, prescale counter; LOAD<=RESET_LOAD.
REQ-026 SHALL abandon any in-flight transaction on reset; first request after release acked normally.

Configuration
REQ-027 SHALL, with WB_TIMER_PRESCALE_EN defined, implement PRESCALE (16 bits, [31:16] read 0) and issue one tick every PRESCALE+1 cycles while EN=1; prescale counter resets when EN written or COUNT written.
REQ-028 SHALL, without WB_TIMER_PRESCALE_EN, tick every cycle; 0x10 reads 0, writes ignored.

Structure
REQ-029 SHALL place register offsets, CTRL/STATUS bit indices and PRESCALE width in package wb_timer_pkg.
REQ-030 SHALL put the prescale divider in sub-module wb_timer_prescaler, instantiated only under WB_TIMER_PRESCALE_EN.

Verification
REQ-031 SHALL cover: read CTRL after reset -> ack one cycle after stb, data 0, ack low next cycle.
REQ-032 SHALL cover: LOAD=5, COUNT=5, CTRL=0x7 -> EXP and irq_o high 5 ticks later, COUNT reloads 5.
REQ-033 SHALL cover: CTRL=0x5 one-shot, COUNT=3 -> after 3 ticks COUNT=0, EN reads 0, irq_o=1; STATUS write 1 -> irq_o=0.
REQ-034 SHALL cover: write LOAD=0xAABBCCDD, sel=4'b0100 over 0 -> LOAD reads 0x00BB0000.
REQ-035 SHALL cover: STATUS clear in exact expiry cycle -> EXP remains 1.
REQ-036 SHALL cover: wb_rst_ni low during ack-pending cycle -> ack never asserts, registers at reset values; with WB_TIMER_PRESCALE_EN, PRESCALE=3 -> COUNT decrements every 4 cycles.

Source files
------------

// File: rtl/wb_timer_pkg.sv
// Shared definitions for the Wishbone timer: register map, CTRL/STATUS bit
// positions, prescaler width and the byte-lane merge helper.
package wb_timer_pkg;

    // Word index taken from wbs_adr_i[4:2]; byte offsets are 0x00, 0x04, 0x08, 0x0C, 0x10.
    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_LOAD     = 3'd1,
        REG_COUNT    = 3'd2,
        REG_STATUS   = 3'd3,
        REG_PRESCALE = 3'd4
    } reg_idx_e;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_AUTO_BIT   = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT = 2;
    localparam int unsigned CTRL_W          = 3;
    localparam int unsigned STATUS_EXP_BIT  = 0;
    localparam int unsigned PRESCALE_W      = 16;

    function automatic logic [31:0] apply_sel(input logic [31:0] cur,
                                              input logic [31:0] wdat,
                                              input logic [3:0]  sel);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = wdat[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_timer_prescaler.sv
// Tick divider for wb_timer: one tick every prescale_i+1 cycles while enabled.
// Only instantiated when WB_TIMER_PRESCALE_EN is defined.
module wb_timer_prescaler
    import wb_timer_pkg::*;
(
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic                  en_i,
    input  logic                  clear_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  tick_o
);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;

    // >= so that lowering PRESCALE mid-run never lets the counter wrap.
    assign tick_o = en_i && (cnt_q >= prescale_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !en_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_timer.sv
// Wishbone classic slave down-counting timer with reload and interrupt.
// Define WB_TIMER_PRESCALE_EN to add the PRESCALE register and tick divider.
module wb_timer
    import wb_timer_pkg::*;
#(
    parameter logic [31:0] RESET_LOAD = 32'h0000_0000,
    parameter bit          IRQ_LEVEL  = 1'b1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    output logic        wbs_ack_o,
    output logic        irq_o
);

    logic              ack_q, ack_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]       load_q, load_d;
    logic [31:0]       count_q, count_d;
    logic              exp_q, exp_d;
    logic              exp_set;
    logic              tick;

    logic     req, wr, rd;
    logic     wr_ctrl, wr_load, wr_count, wr_status;
    reg_idx_e reg_idx;
    logic     addr_unused;

    assign addr_unused = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};

    assign req       = wbs_cyc_i && wbs_stb_i && !ack_q;
    assign wr        = req && wbs_we_i;
    assign rd        = req && !wbs_we_i;
    assign reg_idx   = reg_idx_e'(wbs_adr_i[4:2]);
    assign wr_ctrl   = wr && (reg_idx == REG_CTRL);
    assign wr_load   = wr && (reg_idx == REG_LOAD);
    assign wr_count  = wr && (reg_idx == REG_COUNT);
    assign wr_status = wr && (reg_idx == REG_STATUS);

`ifdef WB_TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  wr_prescale;

    assign wr_prescale = wr && (reg_idx == REG_PRESCALE);

    wb_timer_prescaler u_prescaler (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_ni  (wb_rst_ni),
        .en_i       (ctrl_q[CTRL_EN_BIT]),
        .clear_i    ((wr_ctrl && wbs_sel_i[0]) || wr_count),
        .prescale_i (prescale_q),
        .tick_o     (tick)
    );

    always_comb begin
        prescale_d = prescale_q;
        if (wr_prescale) begin
            for (int b = 0; b < PRESCALE_W / 8; b++) begin
                if (wbs_sel_i[b]) prescale_d[8*b +: 8] = wbs_dat_i[8*b +: 8];
            end
        end
    end
`else
    assign tick = ctrl_q[CTRL_EN_BIT];
`endif

    // NOTE: every variable gets its hold value before any branch, so no latch can be inferred.
    always_comb begin
        ctrl_d  = ctrl_q;
        load_d  = load_q;
        count_d = count_q;
        exp_d   = exp_q;
        exp_set = 1'b0;

        // A bus write to CTRL or COUNT takes precedence over this cycle's countdown.
        if (tick && (count_q != '0) && !(wr_ctrl || wr_count)) begin
            if (count_q == 32'd1) begin
                exp_set = 1'b1;
                if (ctrl_q[CTRL_AUTO_BIT]) begin
                    count_d = load_q;
                end else begin
                    count_d             = '0;
                    ctrl_d[CTRL_EN_BIT] = 1'b0;
                end
            end else begin
                count_d = count_q - 32'd1;
            end
        end

        if (wr_ctrl && wbs_sel_i[0]) ctrl_d  = wbs_dat_i[CTRL_W-1:0];
        if (wr_load)                 load_d  = apply_sel(load_q, wbs_dat_i, wbs_sel_i);
        if (wr_count)                count_d = apply_sel(count_q, wbs_dat_i, wbs_sel_i);

        if (wr_status && wbs_sel_i[0] && wbs_dat_i[STATUS_EXP_BIT]) exp_d = 1'b0;
        if (exp_set) exp_d = 1'b1;
    end

    always_comb begin
        ack_d   = req;
        rdata_d = '0;
        if (rd) begin
            case (reg_idx)
                REG_CTRL:     rdata_d = {{(32-CTRL_W){1'b0}}, ctrl_q};
                REG_LOAD:     rdata_d = load_q;
                REG_COUNT:    rdata_d = count_q;
                REG_STATUS:   rdata_d = {31'b0, exp_q};
`ifdef WB_TIMER_PRESCALE_EN
                REG_PRESCALE: rdata_d = {{(32-PRESCALE_W){1'b0}}, prescale_q};
`endif
                default:      rdata_d = '0;
            endcase
        end
    end

    // NOTE: sequential state updates use non-blocking assignments only.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            ctrl_q     <= '0;
            load_q     <= RESET_LOAD;
            count_q    <= '0;
            exp_q      <= 1'b0;
`ifdef WB_TIMER_PRESCALE_EN
            prescale_q <= '0;
`endif
        end else begin
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            ctrl_q     <= ctrl_d;
            load_q     <= load_d;
            count_q    <= count_d;
            exp_q      <= exp_d;
`ifdef WB_TIMER_PRESCALE_EN
            prescale_q <= prescale_d;
`endif
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdata_q;

    generate
        if (IRQ_LEVEL) begin : g_irq_level
            assign irq_o = exp_q && ctrl_q[CTRL_IRQ_EN_BIT];
        end else begin : g_irq_pulse
            logic irq_q;
            always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
                if (!wb_rst_ni) begin
                    irq_q <= 1'b0;
                end else begin
                    irq_q <= exp_set && ctrl_q[CTRL_IRQ_EN_BIT];
                end
            end
            assign irq_o = irq_q;
        end
    endgenerate

endmodule
